// File: rtl/round_sat_pipe.sv
// Multi-channel pipelined round-and-saturate stage.
// S1 holds each channel's rounded value, S2 holds the clamped output and its flag.
// Valid/ready flow control with a combinational out_ready -> in_ready path,
// plus a sticky counter of saturating output beats.

module round_sat_lane #(
    parameter int Win    = 16,
    parameter int Nsat   = 1,
    parameter int Nround = 5,
    parameter bit SYM    = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        s1_en_i,
    input  logic                        s2_en_i,
    input  logic [1:0]                  mode_i,
    input  logic [Win-1:0]              x_i,
    output logic [Win-Nsat-Nround-1:0]  dout_o,
    output logic                        sat_o
);
    localparam int W1   = Win + 1;
    localparam int RW   = W1 - Nround;
    localparam int WOUT = Win - Nsat - Nround;
    localparam int MAXI = (1 << (WOUT - 1)) - 1;
    localparam int MINI = SYM ? -MAXI : -MAXI - 1;
    localparam logic signed [RW-1:0] MAXV = RW'(MAXI);
    localparam logic signed [RW-1:0] MINV = RW'(MINI);

    // One guard bit so the round-up carry of the largest positive input survives.
    logic [W1-1:0] x;
    assign x = {x_i[Win-1], x_i};

    logic [RW-1:0] y_d, y_q;

    generate
        if (Nround == 0) begin : g_pass
            // Nothing to drop: every mode is a pass-through.
            assign y_d = x;
        end else begin : g_rnd
            localparam logic [Nround-1:0] H = Nround'(2 ** (Nround - 1));
            logic [Nround-1:0] f;
            logic              ge_h, gt_h, inc;

            // Floor of x plus a one-LSB increment chosen by the rounding mode.
            always_comb begin
                f    = x[Nround-1:0];
                ge_h = (f >= H);
                gt_h = (f > H);
                inc  = 1'b0;
                unique case (mode_i)
                    2'd0:    inc = 1'b0;
                    2'd1:    inc = ge_h;
                    2'd2:    inc = gt_h || ((f == H) && x[Nround]);
                    default: inc = x[W1-1] ? gt_h : ge_h;
                endcase
                y_d = x[W1-1:Nround] + RW'(inc);
            end
        end
    endgenerate

    // S1: rounded value, loaded on acceptance of an input beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       y_q <= '0;
        else if (s1_en_i) y_q <= y_d;
    end

    logic signed [RW-1:0] ys;
    logic                 hi, lo;
    logic [WOUT-1:0]      dout_d;
    assign ys = y_q;

    // Clamp to the output range and flag the channel when clamping happened.
    always_comb begin
        hi = (ys > MAXV);
        lo = (ys < MINV);
        if (hi)      dout_d = WOUT'(MAXI);
        else if (lo) dout_d = WOUT'(MINI);
        else         dout_d = y_q[WOUT-1:0];
    end

    logic [WOUT-1:0] dout_q;
    logic            sat_q;

    // S2: saturated output, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
            sat_q  <= 1'b0;
        end else if (s2_en_i) begin
            dout_q <= dout_d;
            sat_q  <= hi || lo;
        end
    end

    assign dout_o = dout_q;
    assign sat_o  = sat_q;
endmodule

module round_sat_pipe #(
    parameter int Win    = 16,
    parameter int Nsat   = 1,
    parameter int Nround = 5,
    parameter int NCH    = 2,
    parameter bit SYM    = 1'b0,
    parameter int CNTW   = 16
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [1:0]                         mode,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [NCH*Win-1:0]                 din,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [NCH*(Win-Nsat-Nround)-1:0]   dout,
    output logic [NCH-1:0]                     sat_flags,
    input  logic                               sat_clr,
    output logic [CNTW-1:0]                    sat_cnt
);
    localparam int WOUT = Win - Nsat - Nround;

    logic [NCH-1:0][Win-1:0]  din_a;
    logic [NCH-1:0][WOUT-1:0] dout_a;
    assign din_a = din;
    assign dout  = dout_a;

    logic s1_vld_q, s1_vld_d, out_vld_q, out_vld_d;
    logic s1_load, s2_load, accept;

    // Stage enables: each stage advances when it is empty or its successor advances.
    always_comb begin
        s2_load   = !out_vld_q || out_ready;
        s1_load   = !s1_vld_q || s2_load;
        in_ready  = reset_n && s1_load;
        accept    = in_valid && in_ready;
        s1_vld_d  = s1_load ? accept : s1_vld_q;
        out_vld_d = s2_load ? s1_vld_q : out_vld_q;
    end

    // Valid bits for both stages; reset empties the pipe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld_q  <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            out_vld_q <= out_vld_d;
        end
    end

    generate
        for (genvar g = 0; g < NCH; g++) begin : g_lane
            round_sat_lane #(
                .Win(Win), .Nsat(Nsat), .Nround(Nround), .SYM(SYM)
            ) u_lane (
                .clk     (clk),
                .rst_n   (reset_n),
                .s1_en_i (accept),
                .s2_en_i (s2_load && s1_vld_q),
                .mode_i  (mode),
                .x_i     (din_a[g]),
                .dout_o  (dout_a[g]),
                .sat_o   (sat_flags[g])
            );
        end
    endgenerate

    logic            fire;
    logic [CNTW-1:0] sat_cnt_d, sat_cnt_q;

    // Count transferred beats with any clamped channel; clear wins but keeps a same-cycle event.
    always_comb begin
        fire = out_vld_q && out_ready && (|sat_flags);
        if (sat_clr)                   sat_cnt_d = CNTW'(fire);
        else if (fire && !(&sat_cnt_q)) sat_cnt_d = sat_cnt_q + 1'b1;
        else                           sat_cnt_d = sat_cnt_q;
    end

    // Saturation event counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sat_cnt_q <= '0;
        else          sat_cnt_q <= sat_cnt_d;
    end

    assign out_valid = out_vld_q;
    assign sat_cnt   = sat_cnt_q;
endmodule
